// File: rtl/mem2_load_unit_if.sv
// Bus bundle for mem2_load_unit: MEM-stage record and DCache read response in,
// WB writeback record out. The design uses 'slave', the upstream/driver side uses 'master'.
interface mem2_load_unit_if #(
  parameter int DST_W = 5
);
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_flush;
  logic [31:0]      mem_pc;
  logic [31:0]      mem_aluout;
  logic [31:0]      mem_outb;
  logic [31:0]      mem_result;
  logic [DST_W-1:0] mem_dst;
  logic             mem_regwr;
  logic             mem_load_en;
  logic [1:0]       mem_load_size;
  logic             mem_load_sign;
  logic [1:0]       mem_load_lr;
  logic             dcache_data_ok;
  logic [31:0]      dcache_rdata;
  logic             wb_stall;
  logic             wb_valid;
  logic [31:0]      wb_pc;
  logic [DST_W-1:0] wb_dst;
  logic             wb_regwr;
  logic [31:0]      wb_wdata;

  modport slave (
    input  mem_valid, mem_flush, mem_pc, mem_aluout, mem_outb, mem_result, mem_dst,
           mem_regwr, mem_load_en, mem_load_size, mem_load_sign, mem_load_lr,
           dcache_data_ok, dcache_rdata, wb_stall,
    output mem_ready, wb_valid, wb_pc, wb_dst, wb_regwr, wb_wdata
  );

  modport master (
    output mem_valid, mem_flush, mem_pc, mem_aluout, mem_outb, mem_result, mem_dst,
           mem_regwr, mem_load_en, mem_load_size, mem_load_sign, mem_load_lr,
           dcache_data_ok, dcache_rdata, wb_stall,
    input  mem_ready, wb_valid, wb_pc, wb_dst, wb_regwr, wb_wdata
  );
endinterface

// File: rtl/mem2_load_unit.sv
// Second memory stage: waits for DCache load data, aligns/extends it and registers the WB record.
// Optional LWL/LWR merge is enabled by defining MEM2_UNALIGNED_LOAD_EN.
module mem2_load_unit #(
  parameter logic [31:0] WB_RST_PC = 32'hBFC0_0000,
  parameter int          DST_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  mem2_load_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic             regwr_q, regwr_d;
  logic [1:0]       addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [31:0]      rdata_q, rdata_d;
`ifdef MEM2_UNALIGNED_LOAD_EN
  logic [1:0]       lr_q, lr_d;
  logic [31:0]      outb_q, outb_d;
  logic [1:0]       sel_lr;
  logic [31:0]      sel_outb;
`endif

  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_pc_q, wb_pc_d;
  logic [DST_W-1:0] wb_dst_q, wb_dst_d;
  logic             wb_regwr_q, wb_regwr_d;
  logic [31:0]      wb_wdata_q, wb_wdata_d;

  logic             accept, complete;
  logic [31:0]      done_pc, done_wdata;
  logic [DST_W-1:0] done_dst;
  logic             done_regwr;
  logic [1:0]       sel_a, sel_size;
  logic             sel_sign;
  logic [31:0]      sel_rdata, load_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign bus.mem_ready = (state_q == IDLE) && !bus.wb_stall && !bus.mem_flush;
  assign accept        = bus.mem_valid && bus.mem_ready;

  // In IDLE the load is aligned straight from the live MEM record; otherwise from the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      sel_a    = bus.mem_aluout[1:0];
      sel_size = bus.mem_load_size;
      sel_sign = bus.mem_load_sign;
`ifdef MEM2_UNALIGNED_LOAD_EN
      sel_lr   = bus.mem_load_lr;
      sel_outb = bus.mem_outb;
`endif
    end else begin
      sel_a    = addr_q;
      sel_size = size_q;
      sel_sign = sign_q;
`ifdef MEM2_UNALIGNED_LOAD_EN
      sel_lr   = lr_q;
      sel_outb = outb_q;
`endif
    end
    sel_rdata = (state_q == HOLD) ? rdata_q : bus.dcache_rdata;
  end

  always_comb begin
    ld_byte = 8'(sel_rdata >> {sel_a, 3'b000});
    ld_half = sel_a[1] ? sel_rdata[31:16] : sel_rdata[15:0];
    case (sel_size)
      2'b00:   load_data = {{24{sel_sign & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{sel_sign & ld_half[15]}}, ld_half};
      default: load_data = sel_rdata;
    endcase
`ifdef MEM2_UNALIGNED_LOAD_EN
    case (sel_lr)
      2'b10:   load_data = (sel_rdata << {2'd3 - sel_a, 3'b000})
                         | (sel_outb & (32'hFFFF_FFFF >> {{1'b0, sel_a} + 3'd1, 3'b000}));
      2'b01:   load_data = (sel_rdata >> {sel_a, 3'b000})
                         | (sel_outb & ~(32'hFFFF_FFFF >> {sel_a, 3'b000}));
      default: ;
    endcase
`endif
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dst_d      = dst_q;
    regwr_d    = regwr_q;
    addr_d     = addr_q;
    size_d     = size_q;
    sign_d     = sign_q;
    rdata_d    = rdata_q;
`ifdef MEM2_UNALIGNED_LOAD_EN
    lr_d       = lr_q;
    outb_d     = outb_q;
`endif
    complete   = 1'b0;
    done_pc    = pc_q;
    done_dst   = dst_q;
    done_regwr = regwr_q;
    done_wdata = load_data;

    case (state_q)
      IDLE: if (accept) begin
        done_pc    = bus.mem_pc;
        done_dst   = bus.mem_dst;
        done_regwr = bus.mem_regwr;
        if (!bus.mem_load_en) begin
          complete   = 1'b1;
          done_wdata = bus.mem_result;
        end else if (bus.dcache_data_ok) begin
          complete = 1'b1;
        end else begin
          pc_d    = bus.mem_pc;
          dst_d   = bus.mem_dst;
          regwr_d = bus.mem_regwr;
          addr_d  = bus.mem_aluout[1:0];
          size_d  = bus.mem_load_size;
          sign_d  = bus.mem_load_sign;
`ifdef MEM2_UNALIGNED_LOAD_EN
          lr_d    = bus.mem_load_lr;
          outb_d  = bus.mem_outb;
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_flush) begin
          state_d = bus.dcache_data_ok ? IDLE : DRAIN;
        end else if (bus.dcache_data_ok) begin
          if (!bus.wb_stall) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            rdata_d = bus.dcache_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.mem_flush) begin
          state_d = IDLE;
        end else if (!bus.wb_stall) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      DRAIN:   if (bus.dcache_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A stalled WB freezes the whole record; otherwise valid reflects this cycle's completion.
    wb_valid_d = wb_valid_q;
    wb_pc_d    = wb_pc_q;
    wb_dst_d   = wb_dst_q;
    wb_regwr_d = wb_regwr_q;
    wb_wdata_d = wb_wdata_q;
    if (!bus.wb_stall) begin
      wb_valid_d = complete;
      if (complete) begin
        wb_pc_d    = done_pc;
        wb_dst_d   = done_dst;
        wb_regwr_d = done_regwr;
        wb_wdata_d = done_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      dst_q      <= '0;
      regwr_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      rdata_q    <= '0;
`ifdef MEM2_UNALIGNED_LOAD_EN
      lr_q       <= '0;
      outb_q     <= '0;
`endif
      wb_valid_q <= 1'b0;
      wb_pc_q    <= WB_RST_PC;
      wb_dst_q   <= '0;
      wb_regwr_q <= 1'b0;
      wb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dst_q      <= dst_d;
      regwr_q    <= regwr_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      rdata_q    <= rdata_d;
`ifdef MEM2_UNALIGNED_LOAD_EN
      lr_q       <= lr_d;
      outb_q     <= outb_d;
`endif
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_dst_q   <= wb_dst_d;
      wb_regwr_q <= wb_regwr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_pc    = wb_pc_q;
  assign bus.wb_dst   = wb_dst_q;
  assign bus.wb_regwr = wb_regwr_q;
  assign bus.wb_wdata = wb_wdata_q;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.mem_aluout[31:2];
`ifndef MEM2_UNALIGNED_LOAD_EN
  logic unused_lr_inputs;
  assign unused_lr_inputs = ^{bus.mem_load_lr, bus.mem_outb};
`endif

`ifndef SYNTHESIS
  // A response with no load waiting for it is an upstream protocol error.
  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (rst)
    !(bus.dcache_data_ok && (state_q == IDLE) && !(accept && bus.mem_load_en)));
`endif

endmodule

// File: tb/tb_mem2_load_unit.sv
// Self-checking bench for mem2_load_unit: vector table for single-cycle records plus
// hand-written multi-cycle sequences; a scoreboard checks every consumed WB record.
module tb_mem2_load_unit;
  localparam int          DST_W  = 5;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem2_load_unit_if #(.DST_W(DST_W)) bus ();
  mem2_load_unit #(.WB_RST_PC(RST_PC), .DST_W(DST_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0]      pc;
    logic [DST_W-1:0] dst;
    logic             regwr;
    logic [31:0]      wdata;
  } exp_t;

  // Field order: load, regwr, size, sign, lr, a, rdata, outb, result, expected wdata
  typedef struct {
    logic        load;
    logic        regwr;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  lr;
    logic [1:0]  a;
    logic [31:0] rdata;
    logic [31:0] outb;
    logic [31:0] result;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_valid      = 1'b0;
    bus.mem_flush      = 1'b0;
    bus.mem_pc         = '0;
    bus.mem_aluout     = '0;
    bus.mem_outb       = '0;
    bus.mem_result     = '0;
    bus.mem_dst        = '0;
    bus.mem_regwr      = 1'b0;
    bus.mem_load_en    = 1'b0;
    bus.mem_load_size  = 2'b00;
    bus.mem_load_sign  = 1'b0;
    bus.mem_load_lr    = 2'b00;
    bus.dcache_data_ok = 1'b0;
    bus.dcache_rdata   = '0;
    bus.wb_stall       = 1'b0;
  endtask

  task automatic drive_rec(input logic [31:0] pc, input logic [DST_W-1:0] dst, input logic regwr,
                           input logic load, input logic [1:0] size, input logic sign,
                           input logic [1:0] lr, input logic [31:0] addr,
                           input logic [31:0] outb, input logic [31:0] result);
    bus.mem_valid     = 1'b1;
    bus.mem_pc        = pc;
    bus.mem_dst       = dst;
    bus.mem_regwr     = regwr;
    bus.mem_load_en   = load;
    bus.mem_load_size = size;
    bus.mem_load_sign = sign;
    bus.mem_load_lr   = lr;
    bus.mem_aluout    = addr;
    bus.mem_outb      = outb;
    bus.mem_result    = result;
  endtask

  task automatic push(input logic [31:0] pc, input logic [DST_W-1:0] dst, input logic regwr,
                      input logic [31:0] wdata);
    exp_t e;
    e.pc = pc; e.dst = dst; e.regwr = regwr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // A record is consumed on a cycle where WB is valid and not stalled.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wb_valid === 1'b1 && bus.wb_stall === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got wb record pc 0x%08h, expected no record", bus.wb_pc);
      end else begin
        mon_e = sb.pop_front();
        check("sb_pc", bus.wb_pc, mon_e.pc);
        check("sb_dst", 32'(bus.wb_dst), 32'(mon_e.dst));
        check("sb_regwr", 32'(bus.wb_regwr), 32'(mon_e.regwr));
        check("sb_wdata", bus.wb_wdata, mon_e.wdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'd0, 32'h0,         32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 2'd2, 32'h0080_0000, 32'h0, 32'h0,         32'hFFFF_FF80});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'd2, 32'h0080_0000, 32'h0, 32'h0,         32'h0000_0080});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 2'd0, 32'h1234_567F, 32'h0, 32'h0,         32'h0000_007F});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 2'd3, 32'h9A00_0000, 32'h0, 32'h0,         32'hFFFF_FF9A});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'd1, 32'h0000_F100, 32'h0, 32'h0,         32'h0000_00F1});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 2'd0, 32'h0000_C0DE, 32'h0, 32'h0,         32'hFFFF_C0DE});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 2'd2, 32'hBEEF_0000, 32'h0, 32'h0,         32'h0000_BEEF});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 2'd2, 32'h7FFF_1234, 32'h0, 32'h0,         32'h0000_7FFF});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b1, 2'b00, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0,         32'hCAFE_F00D});
`ifdef MEM2_UNALIGNED_LOAD_EN
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 2'b10, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 32'hCCDD_3344});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 2'b01, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 32'h11AA_BBCC});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 2'b10, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 32'hDD22_3344});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 2'b01, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 32'h1122_33AA});
`else
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 2'b10, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 32'hAABB_CCDD});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 32'h0000_00CC});
`endif

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_pc", bus.wb_pc, RST_PC);
    check("rst_wb_dst", 32'(bus.wb_dst), 32'd0);
    check("rst_wb_regwr", 32'(bus.wb_regwr), 32'd0);
    check("rst_wb_wdata", bus.wb_wdata, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus.mem_ready), 32'd1);

    // Non-load record, latency 1, then a bubble
    drive_rec(32'h8000_0010, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_1234);
    push(32'h8000_0010, 5'd3, 1'b1, 32'h0000_1234);
    step();
    idle_inputs();
    check("t1_valid", 32'(bus.wb_valid), 32'd1);
    check("t1_dst", 32'(bus.wb_dst), 32'd3);
    check("t1_wdata", bus.wb_wdata, 32'h0000_1234);
    step();
    check("t1_bubble_valid", 32'(bus.wb_valid), 32'd0);
    check("t1_bubble_wdata_hold", bus.wb_wdata, 32'h0000_1234);

    // Back-to-back records with same-cycle load data
    foreach (vecs[i]) begin
      drive_rec(32'h8000_1000 + 32'(i * 4), DST_W'(i + 1), vecs[i].regwr, vecs[i].load,
                vecs[i].size, vecs[i].sign, vecs[i].lr, 32'h1000_0000 | 32'(vecs[i].a),
                vecs[i].outb, vecs[i].result);
      bus.dcache_data_ok = vecs[i].load;
      bus.dcache_rdata   = vecs[i].rdata;
      push(32'h8000_1000 + 32'(i * 4), DST_W'(i + 1), vecs[i].regwr, vecs[i].exp);
      #1;
      check("vec_ready", 32'(bus.mem_ready), 32'd1);
      step();
    end
    idle_inputs();
    step();
    check("vec_bubble_valid", 32'(bus.wb_valid), 32'd0);

    // LH with data 3 cycles after accept
    drive_rec(32'h8000_2000, 5'd9, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 32'h1000_0102, 32'h0, 32'h0);
    push(32'h8000_2000, 5'd9, 1'b1, 32'hFFFF_8001);
    #1;
    check("t3_accept_ready", 32'(bus.mem_ready), 32'd1);
    step();
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        bus.dcache_data_ok = 1'b1;
        bus.dcache_rdata   = 32'h8001_1234;
      end
      #1;
      check("t3_wait_ready", 32'(bus.mem_ready), 32'd0);
      check("t3_wait_valid", 32'(bus.wb_valid), 32'd0);
      step();
      idle_inputs();
    end
    check("t3_valid", 32'(bus.wb_valid), 32'd1);
    check("t3_wdata", bus.wb_wdata, 32'hFFFF_8001);
    check("t3_ready", 32'(bus.mem_ready), 32'd1);

    // Held record under stall, then LW whose data arrives while WB is stalled
    drive_rec(32'h8000_3000, 5'd10, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'hA5A5_A5A5);
    push(32'h8000_3000, 5'd10, 1'b1, 32'hA5A5_A5A5);
    step();
    idle_inputs();
    bus.wb_stall = 1'b1;
    #1;
    check("t4_stall_ready", 32'(bus.mem_ready), 32'd0);
    check("t4_stall_valid", 32'(bus.wb_valid), 32'd1);
    step();
    check("t4_stall_hold_valid", 32'(bus.wb_valid), 32'd1);
    check("t4_stall_hold_wdata", bus.wb_wdata, 32'hA5A5_A5A5);
    bus.wb_stall = 1'b0;
    drive_rec(32'h8000_3004, 5'd11, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h1000_0200, 32'h0, 32'h0);
    push(32'h8000_3004, 5'd11, 1'b1, 32'h1122_3344);
    step();
    idle_inputs();
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'h1122_3344;
    bus.wb_stall       = 1'b1;
    step();
    idle_inputs();
    bus.wb_stall = 1'b1;
    #1;
    check("t4_hold_valid", 32'(bus.wb_valid), 32'd0);
    check("t4_hold_old_wdata", bus.wb_wdata, 32'hA5A5_A5A5);
    check("t4_hold_ready", 32'(bus.mem_ready), 32'd0);
    step();
    check("t4_hold2_old_wdata", bus.wb_wdata, 32'hA5A5_A5A5);
    bus.wb_stall = 1'b0;
    #1;
    check("t4_release_ready", 32'(bus.mem_ready), 32'd0);
    step();
    check("t4_valid", 32'(bus.wb_valid), 32'd1);
    check("t4_wdata", bus.wb_wdata, 32'h1122_3344);
    check("t4_pc", bus.wb_pc, 32'h8000_3004);
    check("t4_ready", 32'(bus.mem_ready), 32'd1);
    step();

    // Flush in WAIT, response 2 cycles later is drained
    drive_rec(32'h8000_4000, 5'd12, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h1000_0300, 32'h0, 32'h0);
    step();
    idle_inputs();
    bus.mem_flush = 1'b1;
    #1;
    check("t5_flush_ready", 32'(bus.mem_ready), 32'd0);
    step();
    idle_inputs();
    #1;
    check("t5_drain_ready", 32'(bus.mem_ready), 32'd0);
    step();
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'hDEAD_0000;
    #1;
    check("t5_drain_data_ready", 32'(bus.mem_ready), 32'd0);
    step();
    idle_inputs();
    #1;
    check("t5_after_ready", 32'(bus.mem_ready), 32'd1);
    check("t5_after_valid", 32'(bus.wb_valid), 32'd0);
    check("t5_wb_kept", bus.wb_wdata, 32'h1122_3344);

    // Flush and data_ok in the same WAIT cycle
    drive_rec(32'h8000_4100, 5'd13, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h1000_0400, 32'h0, 32'h0);
    step();
    idle_inputs();
    bus.mem_flush      = 1'b1;
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'h5555_5555;
    step();
    idle_inputs();
    #1;
    check("t5b_ready", 32'(bus.mem_ready), 32'd1);
    check("t5b_valid", 32'(bus.wb_valid), 32'd0);
    check("t5b_wdata", bus.wb_wdata, 32'h1122_3344);

    // Flush while in HOLD discards the latched data
    drive_rec(32'h8000_4200, 5'd14, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h1000_0500, 32'h0, 32'h0);
    step();
    idle_inputs();
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'h6666_6666;
    bus.wb_stall       = 1'b1;
    step();
    idle_inputs();
    bus.wb_stall  = 1'b1;
    bus.mem_flush = 1'b1;
    step();
    idle_inputs();
    #1;
    check("t5c_ready", 32'(bus.mem_ready), 32'd1);
    step();
    check("t5c_valid", 32'(bus.wb_valid), 32'd0);
    check("t5c_wdata", bus.wb_wdata, 32'h1122_3344);

    // Flush blocks acceptance in IDLE
    drive_rec(32'h8000_4300, 5'd15, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h7777_7777);
    bus.mem_flush = 1'b1;
    #1;
    check("t6_flush_ready", 32'(bus.mem_ready), 32'd0);
    step();
    idle_inputs();
    check("t6_valid", 32'(bus.wb_valid), 32'd0);

    // Reset while waiting drops the load
    drive_rec(32'h8000_5000, 5'd16, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h1000_0600, 32'h0, 32'h0);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t7_ready", 32'(bus.mem_ready), 32'd1);
    check("t7_wb_pc", bus.wb_pc, RST_PC);
    check("t7_wb_wdata", bus.wb_wdata, 32'd0);
    drive_rec(32'h8000_5004, 5'd17, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0077);
    push(32'h8000_5004, 5'd17, 1'b1, 32'h0000_0077);
    step();
    idle_inputs();
    check("t7_valid", 32'(bus.wb_valid), 32'd1);
    step();
    step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem2_load_unit.md
Name: mem2_load_unit

Overview:
- Second memory stage; sits directly downstream of the EXE/MEM pipeline register.
- Consumes the registered MEM-stage record and waits for the DCache read response of loads issued in EXE.
- Aligns and extends load data, merges it with non-load results, and registers a writeback record for the WB stage.
- Stalls the MEM stage while a load response is pending, and discards responses that belong to flushed loads.

Parameters:
WB_RST_PC, 32'hBFC0_0000, reset value of wb_pc
DST_W, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mem_valid  in  1  MEM record valid
mem_ready  out  1  block accepts MEM record this cycle
mem_flush  in  1  kill the MEM record and any un-retired load held here
mem_pc  in  32  instruction PC
mem_aluout  in  32  ALU result / load address
mem_outb  in  32  old rt value (LWL/LWR merge)
mem_result  in  32  non-load writeback value
mem_dst  in  DST_W  destination register
mem_regwr  in  1  record writes register file
mem_load_en  in  1  record is a load
mem_load_size  in  2  00 byte, 01 half, 10 word
mem_load_sign  in  1  1 = sign-extend
mem_load_lr  in  2  00 normal, 10 LWL, 01 LWR
dcache_data_ok  in  1  read data valid (one pulse per issued load)
dcache_rdata  in  32  read data
wb_stall  in  1  WB cannot accept
wb_valid  out  1  writeback record valid
wb_pc  out  32  record PC
wb_dst  out  DST_W  destination
wb_regwr  out  1  register write enable
wb_wdata  out  32  writeback data

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, wb_valid=0, wb_pc=WB_RST_PC, wb_dst=0, wb_regwr=0, wb_wdata=0, hold registers=0. Reset mid-wait drops the pending load without a drain.
- FSM states:
  - IDLE
  - WAIT: load accepted, data not yet arrived.
  - HOLD: data arrived while wb_stall=1.
  - DRAIN: flushed while in WAIT; swallow one response.
- mem_ready = (state==IDLE) && !wb_stall && !mem_flush.
- Accept occurs when mem_valid && mem_ready.
- Non-load accept: wb record loaded at the next posedge; latency 1. wb_wdata=mem_result.
- Load accept with dcache_data_ok=1 in the same cycle: aligned data written to wb at the next posedge; stay IDLE.
- Load accept without data_ok: capture pc/dst/regwr/addr[1:0]/size/sign/lr/outb; go to WAIT.
- WAIT transitions:
  - data_ok && !wb_stall && !mem_flush: write wb, go IDLE.
  - data_ok && wb_stall && !mem_flush: latch rdata, go HOLD.
  - mem_flush && !data_ok: go DRAIN.
  - mem_flush && data_ok: discard the response, go IDLE.
- HOLD transitions:
  - !wb_stall: write wb, go IDLE.
  - mem_flush: discard, go IDLE (flush wins over write).
- DRAIN: on data_ok, discard and go IDLE; mem_ready=0 throughout.
- wb register update rules:
  - wb_stall=1: wb register holds.
  - wb_stall=0 and nothing completes: wb_valid<=0; other wb fields hold.
- mem_flush never clears the wb register.
- Alignment uses a=addr[1:0], little-endian:
  - byte: rdata[8a+7:8a].
  - half: rdata[16*a[1]+15:16*a[1]].
  - word: rdata.
  - Byte/half are extended per sign (sign-extend when 1, zero-extend when 0).
- Misaligned half/word never arrive here; exceptions are raised upstream.
- data_ok in IDLE with no load being accepted is a protocol violation: ignored, and an assertion fires in simulation.

Optional Feature:
- Macro: MEM2_UNALIGNED_LOAD_EN.
- Defined, LWL: wb_wdata = (rdata << 8*(3-a)) | (outb & (32'hFFFFFFFF >> 8*(a+1))).
- Defined, LWR: wb_wdata = (rdata >> 8*a) | (outb & ~(32'hFFFFFFFF >> 8*a)).
- Not defined: mem_load_lr is ignored and the load is treated per mem_load_size; the outb hold register is not instantiated.

Test Plan:
1. Reset, then a non-load record (pc=0x80000010, dst=3, result=0x1234) with wb_stall=0 -> the next cycle wb_valid=1, wb_dst=3, wb_wdata=0x1234; after that, a bubble cycle gives wb_valid=0.
2. LB, addr=...02, sign=1, data_ok in the same cycle with rdata=0x00800000 -> next cycle wb_wdata=0xFFFFFF80. Repeat with LBU -> 0x00000080.
3. LH, addr=...02, rdata=0x8001xxxx delivered 3 cycles after accept -> mem_ready=0 for those 3 cycles; wb_wdata=0xFFFF8001 one cycle after data_ok.
4. LW in WAIT; data_ok=0x11223344 with wb_stall=1 for 2 cycles -> state HOLD; wb holds its old record; when the stall releases, wb_wdata=0x11223344.
5. LW in WAIT, mem_flush pulse, then data_ok 2 cycles later -> response discarded, wb_valid stays 0, mem_ready=1 the cycle after data_ok. Also cover flush and data_ok in the same cycle -> discarded, IDLE next cycle.
6. (Macro defined) LWL a=1, rdata=0xAABBCCDD, outb=0x11223344 -> 0xCCDD3344. LWR a=1 with the same data -> 0x11AABBCC.
